fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage:
// FSM state encoding, datapath widths, reset defaults and PC increment helper.
package fetch_stage_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0]    RESET_PC_DEF  = 8'h00;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  // Modulo-2^PC_W increment: 8'hFF wraps to 8'h00 silently.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear-to-bubble has priority over load, otherwise holds.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_plus1_i,
  input  logic               valid_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_plus1_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_plus1_q;
  logic               valid_q;

  // Pipeline register with async reset and synchronous bubble insertion.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= 8'h00;
      valid_q    <= 1'b0;
    end else if (clr_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= 8'h00;
      valid_q    <= 1'b0;
    end else if (en_i) begin
      instr_q    <= instr_i;
      pc_plus1_q <= pc_plus1_i;
      valid_q    <= valid_i;
    end else begin
      instr_q    <= instr_q;
      pc_plus1_q <= pc_plus1_q;
      valid_q    <= valid_q;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-entry skid buffer for decode stalls, and a
// request FSM that keeps an outstanding memory request stable across redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               StallD,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    BranchTargetE,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCPlus1D,
  output logic               ValidD
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pcf_q, pcf_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc1_q, skid_pc1_d;
  logic               skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]    drop_addr_q, drop_addr_d;
  logic               imem_req_q, imem_req_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;

  logic [PC_W-1:0]    pcf_inc_s;
  logic               ifid_en_s;
  logic               ifid_clr_s;
  logic [INSTR_W-1:0] ifid_instr_s;
  logic [PC_W-1:0]    ifid_pc1_s;
  logic               ifid_valid_s;

  assign pcf_inc_s = pc_inc(pcf_q);

  // Next-state logic; a redirect always wins over stall and memory handshake.
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    skid_instr_d = skid_instr_q;
    skid_pc1_d   = skid_pc1_q;
    skid_valid_d = skid_valid_q;
    drop_addr_d  = drop_addr_q;
    ifid_en_s    = 1'b0;
    ifid_clr_s   = 1'b0;
    ifid_instr_s = imem_rdata;
    ifid_pc1_s   = pcf_inc_s;
    ifid_valid_s = 1'b1;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (PCSrcE) begin
          pcf_d        = BranchTargetE;
          ifid_clr_s   = 1'b1;
          skid_valid_d = 1'b0;
          if (imem_ready) begin
            state_d = ST_FETCH;
          end else begin
            state_d     = ST_DROP;
            drop_addr_d = imem_addr_q;
          end
        end else if (imem_ready && !StallD) begin
          ifid_en_s = 1'b1;
          pcf_d     = pcf_inc_s;
        end else if (imem_ready) begin
          skid_instr_d = imem_rdata;
          skid_pc1_d   = pcf_inc_s;
          skid_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end else if (!StallD) begin
          ifid_clr_s = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          pcf_d        = BranchTargetE;
          ifid_clr_s   = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (!StallD) begin
          ifid_en_s    = 1'b1;
          ifid_instr_s = skid_instr_q;
          ifid_pc1_s   = skid_pc1_q;
          ifid_valid_s = skid_valid_q;
          pcf_d        = pcf_inc_s;
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        // The pending wrong-path word is thrown away; IF/ID stays a bubble.
        ifid_clr_s = 1'b1;
        if (PCSrcE) begin
          pcf_d   = BranchTargetE;
          state_d = ST_DROP;
        end else if (imem_ready) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
    imem_req_d  = (state_d == ST_FETCH) || (state_d == ST_DROP);
    imem_addr_d = (state_d == ST_DROP) ? drop_addr_d : pcf_d;
  end

  // FSM, PC, skid buffer and registered memory-request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RST;
      pcf_q        <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc1_q   <= 8'h00;
      skid_valid_q <= 1'b0;
      drop_addr_q  <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      skid_instr_q <= skid_instr_d;
      skid_pc1_q   <= skid_pc1_d;
      skid_valid_q <= skid_valid_d;
      drop_addr_q  <= drop_addr_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n_i    (reset),
    .en_i       (ifid_en_s),
    .clr_i      (ifid_clr_s),
    .instr_i    (ifid_instr_s),
    .pc_plus1_i (ifid_pc1_s),
    .valid_i    (ifid_valid_s),
    .instr_o    (InstrD),
    .pc_plus1_o (PCPlus1D),
    .valid_o    (ValidD)
  );

endmodule
